par_rx: RTL and testbench
=========================

PAR_RX -- requirements
Module: par_rx

Interface
REQ-001 Parameter DW, default 8, number of data bits per frame (legal 5..16).
REQ-002 Parameter OVS, default 4, clock cycles per bit period (even, legal 4..64).
REQ-003 Parameter ODD, default 0: 0 = even parity expected, 1 = odd parity expected.
REQ-004 ck  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rxd  input  1  asynchronous serial line; idle high, LSB first.
REQ-007 q_data  output  DW  last received data word.
REQ-008 q_valid  output  1  one-cycle pulse: q_data, q_perr and q_ferr updated.
REQ-009 q_perr  output  1  parity error flag of the last frame.
REQ-010 q_ferr  output  1  framing error flag (stop bit sampled 0) of the last frame.
REQ-011 busy  output  1  high while the FSM is outside IDLE.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer (reset value 1) before any use; the synchronized signal is rxs.
REQ-013 FSM states SHALL be IDLE, START, DATA, PAR, STOP, BREAK.
REQ-014 IDLE: rxs=0 -> START with cnt=0.
REQ-015 START: cnt increments each cycle; at cnt=OVS/2-1, rxs=1 -> IDLE (glitch rejected, no q_valid); rxs=0 -> DATA with cnt=0, bit index=0, parity accumulator=ODD.
REQ-016 DATA: sample at cnt=OVS-1, then cnt wraps to 0; sampled bit shifts into the MSB of the shift register (LSB first on the line) and XORs into the accumulator; after bit DW-1 -> PAR.
REQ-017 PAR: sample at cnt=OVS-1; the sample XORs into the accumulator; -> STOP.
REQ-018 STOP: sample at cnt=OVS-1; in the next cycle q_valid=1 for exactly one cycle, q_data=shift register, q_perr=accumulator, q_ferr=~sample.
REQ-019 After STOP: stop sample 1 -> IDLE; stop sample 0 -> BREAK.
REQ-020 BREAK: remain until rxs=1, then -> IDLE; no start detection while in BREAK.
REQ-021 q_data, q_perr, q_ferr SHALL hold their values between q_valid pulses.
REQ-022 A frame start SHALL be accepted in the cycle immediately after the STOP state is left (back-to-back frames).
REQ-023 cnt width SHALL be $clog2(OVS); bit index width SHALL be $clog2(DW); no counter exceeds its terminal value.

Reset
REQ-024 rst=1 SHALL force IDLE, cnt=0, synchronizer=1, shift register=0, q_data=0, q_valid=0, q_perr=0, q_ferr=0, busy=0 on the next rising edge.
REQ-025 rst asserted mid-frame SHALL abandon the frame with no q_valid pulse; reception restarts only on a new falling edge after rst is released.

Structure
REQ-026 Package par_rx_pkg SHALL hold the FSM state enum and the helper function computing counter widths.
REQ-027 The synchronizer SHALL be a separate sub-module par_rx_sync (one bit, 2 flops, reset value parameter).
REQ-028 All remaining logic (FSM, counters, shifter, parity XOR) SHALL reside in par_rx.

Verification (DW=8, OVS=4, ODD=0)
REQ-029 Frame 0xA5, parity bit 0, stop bit 1 -> one q_valid pulse, q_data=0xA5, q_perr=0, q_ferr=0.
REQ-030 Frame 0xA5, parity bit 1 -> q_data=0xA5, q_perr=1, q_ferr=0.
REQ-031 Frame 0x3C, parity bit 0, stop bit 0, line held low 20 cycles -> q_ferr=1, busy stays high until rxd returns high, no second q_valid.
REQ-032 rxd low for 1 cycle, then high -> no q_valid, busy returns to 0 within OVS/2+3 cycles.
REQ-033 rst pulsed during data bit 4 of a frame, then a clean 0x5A frame -> no pulse for the aborted frame; q_data=0x5A, q_perr=0.
REQ-034 Back-to-back frames 0x00 then 0xFF, each with parity bit 0, no idle gap -> two q_valid pulses 11*OVS cycles apart, both with q_perr=0, q_ferr=0.

Source files
------------

// File: rtl/par_rx_pkg.sv
// rtl/par_rx_pkg.sv - shared types and sizing helpers for the parity serial receiver
package par_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BREAK = 3'd5
    } rx_state_t;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/par_rx_sync.sv
// rtl/par_rx_sync.sv - two-flop synchronizer for one asynchronous bit
module par_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic ck,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge ck) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/par_rx.sv
// rtl/par_rx.sv - oversampling serial receiver with parity and framing checks
module par_rx
    import par_rx_pkg::*;
#(
    parameter int DW  = 8,
    parameter int OVS = 4,
    parameter int ODD = 0
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          rxd,
    output logic [DW-1:0] q_data,
    output logic          q_valid,
    output logic          q_perr,
    output logic          q_ferr,
    output logic          busy
);

    localparam int CW = ctr_width(OVS);
    localparam int IW = ctr_width(DW);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DW - 1);

    rx_state_t      state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [IW-1:0]  idx, idx_n;
    logic [DW-1:0]  sr, sr_n;
    logic           acc, acc_n;
    logic           done;
    logic           rxs;

    par_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .ck  (ck),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sr      <= '0;
            acc     <= 1'b0;
            q_data  <= '0;
            q_valid <= 1'b0;
            q_perr  <= 1'b0;
            q_ferr  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sr      <= sr_n;
            acc     <= acc_n;
            q_valid <= done;
            if (done) begin
                q_data <= sr;
                q_perr <= acc;
                q_ferr <= ~rxs;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sr_n    = sr;
        acc_n   = acc;
        done    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            // Half a bit in: a line that is high again was only a glitch.
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (rxs) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        idx_n   = '0;
                        acc_n   = 1'(ODD);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    sr_n  = {rxs, sr[DW-1:1]};
                    acc_n = acc ^ rxs;
                    if (idx == IDX_LAST) state_n = PAR;
                    else                 idx_n   = idx + IW'(1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PAR: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    acc_n   = acc ^ rxs;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    done    = 1'b1;
                    state_n = rxs ? IDLE : BREAK;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            // A held-low line must go high before another start can be seen.
            BREAK: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_par_rx.sv
// tb/tb_par_rx.sv - self-checking bench for par_rx
module tb_par_rx;

    localparam int DW  = 8;
    localparam int OVS = 4;
    localparam int ODD = 0;
    localparam int NV  = 7;

    logic          ck  = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic [DW-1:0] q_data;
    logic          q_valid;
    logic          q_perr;
    logic          q_ferr;
    logic          busy;

    par_rx #(.DW(DW), .OVS(OVS), .ODD(ODD)) dut (
        .ck      (ck),
        .rst     (rst),
        .rxd     (rxd),
        .q_data  (q_data),
        .q_valid (q_valid),
        .q_perr  (q_perr),
        .q_ferr  (q_ferr),
        .busy    (busy)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] e_data;
        logic       e_perr;
        logic       e_ferr;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[NV];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_pulses   = 0;
    int   exp_pulses = 0;
    int   cyc        = 0;
    int   pulse_last = 0;
    int   pulse_prev = 0;

    always @(posedge ck) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge ck) begin
        if (q_valid) begin
            exp_t e;
            n_pulses++;
            pulse_prev = pulse_last;
            pulse_last = cyc;
            if (sb.size() == 0) begin
                check("unexpected_q_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("q_data", 32'(q_data), 32'(e.data));
                check("q_perr", 32'(q_perr), 32'(e.perr));
                check("q_ferr", 32'(q_ferr), 32'(e.ferr));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        tick(OVS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        sb.push_back(e);
        exp_pulses++;
    endtask

    initial begin
        int   pulses_before;
        logic seen_busy;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[6] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};

        rst = 1'b1;
        rxd = 1'b1;
        tick(3);
        check("reset_q_data",  32'(q_data),  32'd0);
        check("reset_q_valid", 32'(q_valid), 32'd0);
        check("reset_q_perr",  32'(q_perr),  32'd0);
        check("reset_q_ferr",  32'(q_ferr),  32'd0);
        check("reset_busy",    32'(busy),    32'd0);
        rst = 1'b0;
        tick(2 * OVS);

        for (int v = 0; v < NV; v++) begin
            expect_frame(vecs[v].e_data, vecs[v].e_perr, vecs[v].e_ferr);
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
            rxd = 1'b1;
            tick(2 * OVS);
            check($sformatf("drain_vec%0d", v), 32'(sb.size()), 32'd0);
            check($sformatf("idle_vec%0d", v), 32'(busy), 32'd0);
        end

        // Break: stop bit low and the line held low afterwards.
        expect_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        tick(20);
        check("break_busy_held", 32'(busy), 32'd1);
        check("break_ferr_held", 32'(q_ferr), 32'd1);
        check("break_drain", 32'(sb.size()), 32'd0);
        rxd = 1'b1;
        tick(4);
        check("break_release_busy", 32'(busy), 32'd0);
        tick(2 * OVS);

        // One-cycle glitch is rejected.
        pulses_before = n_pulses;
        seen_busy = 1'b0;
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        for (int i = 0; i < OVS / 2 + 3; i++) begin
            tick(1);
            seen_busy |= busy;
        end
        check("glitch_seen_busy", 32'(seen_busy), 32'd1);
        check("glitch_busy_clear", 32'(busy), 32'd0);
        tick(2 * OVS);
        check("glitch_no_pulse", 32'(n_pulses), 32'(pulses_before));

        // Reset in the middle of data bit 4 abandons the frame.
        pulses_before = n_pulses;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rxd = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        tick(3 * OVS);
        check("abort_no_pulse", 32'(n_pulses), 32'(pulses_before));
        expect_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);
        tick(2 * OVS);
        check("abort_drain", 32'(sb.size()), 32'd0);

        // Back-to-back frames with no idle gap.
        expect_frame(8'h00, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        rxd = 1'b1;
        tick(2 * OVS);
        check("b2b_drain", 32'(sb.size()), 32'd0);
        check("b2b_gap", 32'(pulse_last - pulse_prev), 32'(11 * OVS));

        check("total_pulses", 32'(n_pulses), 32'(exp_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
